// File: rtl/fb_clocked_video_out.sv
// Clocked-video output stage: pixel FIFO, raster timing generator and frame alignment FSM.
// Optional FB_CVO_TEST_PATTERN_EN adds a test_pattern input that replaces pixels with {h_cnt,v_cnt}.
module fb_clocked_video_out #(
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 16,
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter bit HS_POL     = 1'b0,
  parameter bit VS_POL     = 1'b0
) (
  input  logic              clk_clk,
  input  logic              reset_reset_n,
  input  logic              enable,
  input  logic [DATA_W-1:0] din_data,
  input  logic              din_valid,
  output logic              din_ready,
  input  logic              din_startofpacket,
`ifdef FB_CVO_TEST_PATTERN_EN
  input  logic              test_pattern,
`endif
  output logic [DATA_W-1:0] vid_data,
  output logic              vid_datavalid,
  output logic              vid_h_sync,
  output logic              vid_v_sync,
  output logic              vid_h,
  output logic              vid_v,
  output logic              vid_f,
  output logic              underflow,
  output logic              underflow_sticky,
  input  logic              clear_underflow
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);
  localparam int AW      = $clog2(FIFO_DEPTH);
  localparam int CW      = AW + 1;

  localparam logic [HW-1:0] H_ACT   = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_BEG  = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END  = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [HW-1:0] H_LAST  = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT   = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_BEG  = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END  = VW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [VW-1:0] V_LAST  = VW'(V_TOTAL - 1);

  typedef enum logic [1:0] {IDLE, ALIGN, WAIT_FRAME, STREAM} state_t;

  state_t            state, state_next;
  logic [HW-1:0]     h_cnt;
  logic [VW-1:0]     v_cnt;
  logic              active, origin, hs_on, vs_on;

  logic [DATA_W:0]   mem [FIFO_DEPTH];
  logic [AW-1:0]     rd_ptr, wr_ptr;
  logic [CW-1:0]     count, count_next;
  logic              empty, push, pop, head_sop;
  logic [DATA_W-1:0] head_data, pixel;
  logic              pix_take, uf;

  assign active = (h_cnt < H_ACT) && (v_cnt < V_ACT);
  assign origin = (h_cnt == '0) && (v_cnt == '0);
  assign hs_on  = (h_cnt >= HS_BEG) && (h_cnt < HS_END);
  assign vs_on  = (v_cnt >= VS_BEG) && (v_cnt < VS_END);
  assign vid_f  = 1'b0;

  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_cnt == H_LAST) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + VW'(1);
    end else begin
      h_cnt <= h_cnt + HW'(1);
    end
  end

  assign empty      = (count == '0);
  assign head_sop   = mem[rd_ptr][DATA_W];
  assign head_data  = mem[rd_ptr][DATA_W-1:0];
  assign push       = din_valid && din_ready && enable;
  assign count_next = count + CW'(push) - CW'(pop);

  always_ff @(posedge clk_clk) begin
    if (push) mem[wr_ptr] <= {din_startofpacket, din_data};
  end

  // Dropping enable flushes the FIFO; ready is precomputed from the next occupancy.
  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n || !enable) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      din_ready <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count     <= count_next;
      din_ready <= (count_next < CW'(FIFO_DEPTH));
    end
  end

  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) state <= IDLE;
    else                state <= state_next;
  end

  always_comb begin
    state_next = state;
    pop        = 1'b0;
    pix_take   = 1'b0;
    uf         = 1'b0;
    if (!enable) begin
      state_next = IDLE;
    end
`ifdef FB_CVO_TEST_PATTERN_EN
    else if (test_pattern) begin
      state_next = state;
    end
`endif
    else begin
      case (state)
        IDLE: state_next = ALIGN;
        ALIGN: begin
          if (!empty) begin
            if (head_sop) state_next = WAIT_FRAME;
            else          pop        = 1'b1;
          end
        end
        WAIT_FRAME: begin
          if (origin && !empty) begin
            state_next = STREAM;
            pop        = 1'b1;
            pix_take   = 1'b1;
          end
        end
        STREAM: begin
          // A frame must start exactly at (0,0); any mismatch forces realignment.
          if (active) begin
            if (empty) begin
              uf         = 1'b1;
              state_next = ALIGN;
            end else if (origin) begin
              if (head_sop) begin
                pop      = 1'b1;
                pix_take = 1'b1;
              end else begin
                uf         = 1'b1;
                state_next = ALIGN;
              end
            end else if (head_sop) begin
              uf         = 1'b1;
              state_next = WAIT_FRAME;
            end else begin
              pop      = 1'b1;
              pix_take = 1'b1;
            end
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_comb begin
    pixel = pix_take ? head_data : '0;
`ifdef FB_CVO_TEST_PATTERN_EN
    if (test_pattern && active) pixel = DATA_W'({h_cnt, v_cnt});
`endif
  end

  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      vid_data         <= '0;
      vid_datavalid    <= 1'b0;
      vid_h_sync       <= ~HS_POL;
      vid_v_sync       <= ~VS_POL;
      vid_h            <= 1'b0;
      vid_v            <= 1'b0;
      underflow        <= 1'b0;
      underflow_sticky <= 1'b0;
    end else begin
      vid_data         <= pixel;
      vid_datavalid    <= active;
      vid_h_sync       <= hs_on ? HS_POL : ~HS_POL;
      vid_v_sync       <= vs_on ? VS_POL : ~VS_POL;
      vid_h            <= (h_cnt >= H_ACT);
      vid_v            <= (v_cnt >= V_ACT);
      underflow        <= uf;
      underflow_sticky <= uf | (underflow_sticky & ~clear_underflow);
    end
  end

endmodule

// File: doc/fb_clocked_video_out.md
# fb_clocked_video_out

Parametrised clocked-video output stage for the framebuffer path: accepts an Avalon-ST pixel stream from the frame reader, buffers it in an internal FIFO and emits it against a programmable raster timing on the single system clock. Successor to the fixed VIP clocked-video output. Adds generic pixel width, FIFO depth, raster geometry and sync polarity, plus frame re-alignment on `startofpacket` and sticky underflow reporting. Sits between the frame reader and the DVI/VGA pin drivers in the top level.

## Interface
- `DATA_W`, 32: pixel width, bits
- `FIFO_DEPTH`, 16: pixel FIFO entries, power of two, ≥4
- `H_ACTIVE`, 640 / `H_FP`, 16 / `H_SYNC`, 96 / `H_BP`, 48: horizontal geometry, pixels, each ≥1
- `V_ACTIVE`, 480 / `V_FP`, 10 / `V_SYNC`, 2 / `V_BP`, 33: vertical geometry, lines, each ≥1
- `HS_POL`, 0 / `VS_POL`, 0: sync level when asserted (0 = active-low)

- `clk_clk` in 1: sole clock; pixel clock = system clock
- `reset_reset_n` in 1: reset, synchronous, active-low
- `enable` in 1: stream enable
- `din_data` in DATA_W: pixel
- `din_valid` in 1 / `din_ready` out 1: Avalon-ST handshake
- `din_startofpacket` in 1: first pixel of frame
- `vid_data` out DATA_W: output pixel
- `vid_datavalid` out 1: active-region pixel
- `vid_h_sync` / `vid_v_sync` out 1: syncs, polarity per HS_POL/VS_POL
- `vid_h` / `vid_v` out 1: horizontal / vertical blanking
- `vid_f` out 1: field, tied 0 (progressive)
- `underflow` out 1: one-cycle pulse per underflow event
- `underflow_sticky` out 1: set by `underflow`, cleared by `clear_underflow`
- `clear_underflow` in 1: clears sticky flag

## Operation
- Counters `h_cnt` 0..H_TOTAL-1, `v_cnt` 0..V_TOTAL-1 (TOTAL = sum of four). Free-run from reset; `h_cnt` wraps → `v_cnt` increments, wraps at V_TOTAL.
- Active: `h_cnt<H_ACTIVE && v_cnt<V_ACTIVE`. hsync asserted for `h_cnt` in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC); vsync likewise on `v_cnt`. `vid_h` = `h_cnt>=H_ACTIVE`; `vid_v` = `v_cnt>=V_ACTIVE`.
- FIFO stores {sop, data}. `din_ready` = FIFO not full. Write on `din_valid && din_ready`.
- FSM:
  - IDLE: no pops; `enable`=1 → ALIGN.
  - ALIGN: pop one word/cycle while head has sop=0; head sop=1 → WAIT_FRAME.
  - WAIT_FRAME: hold; at `h_cnt==0 && v_cnt==0` → STREAM, pop that cycle.
  - STREAM: pop one word per active pixel. Active pixel with FIFO empty → `underflow`, black pixel, → ALIGN. Head sop=1 at active pixel other than (0,0) (short frame) → `underflow`, no pop, → WAIT_FRAME. Head sop=0 at (0,0) (long frame) → `underflow`, → ALIGN.
- Non-STREAM states: active pixels output `vid_data`=0, `vid_datavalid`=1; timing continues unbroken.
- `enable`=0 in any state → IDLE next cycle and FIFO flushed; `din_ready` held 0 while `enable`=0.
- `clear_underflow` and `underflow` same cycle: set wins.

## Timing
- All outputs registered; timing outputs lag the counter state by 1 cycle; `vid_data` is the word popped in the previous cycle.
- Word written into empty FIFO is poppable the next cycle.
- Reset values: counters 0, FSM IDLE, FIFO empty, `vid_data` 0, `vid_datavalid` 0, syncs deasserted (`~HS_POL`, `~VS_POL`), `vid_h` 0, `vid_v` 0, `vid_f` 0, `underflow` 0, `underflow_sticky` 0, `din_ready` 0.
- Reset mid-frame: all state as above on next edge; in-flight pixels discarded.
- Simultaneous push and pop on full FIFO: not allowed (`din_ready`=0 when full).

## Configuration
- `FB_CVO_TEST_PATTERN_EN` defined: adds input `test_pattern`; when 1, active pixels output `{h_cnt,v_cnt}` zero-extended/truncated to DATA_W with `vid_datavalid`=1, FIFO not popped, no underflow raised, FSM frozen. Undefined: port absent, pixels only from FIFO.

## Test plan
Geometry H 4/1/2/1 (H_TOTAL 8), V 2/1/1/1 (V_TOTAL 5), 40-cycle frame.
- Reset, `enable`=0 → hsync low for `h_cnt` 5–6, vsync low on line 3, `vid_datavalid` high 8 cycles/frame with data 0, `din_ready`=0.
- Preload 8 pixels 0x1..0x8, SOP on first, `enable`=1 → frame 1 emits 0x1..0x8 in order, no underflow.
- Supply only 6 pixels → pixel 7 output 0, `underflow` one pulse, sticky 1; `clear_underflow` → 0.
- Send 3 non-SOP words then a frame → 3 words discarded in ALIGN, next frame shows correct data.
- Next frame's SOP arrives after 5 pixels → underflow at pixel 6, frame realigns at next (0,0).
- Reset asserted mid-STREAM → all outputs at reset values next cycle, FIFO empty.
